// File: rtl/brew_plant.sv
// Behavioural brew vat: turns FSM actuator commands into temp/level sensor readings.
// Integer, prescaler-driven dynamics; all outputs registered.
module brew_plant #(
    parameter logic [7:0]  AMBIENT   = 8'd20,
    parameter int unsigned HEAT_DIV  = 4,
    parameter int unsigned COOL_DIV  = 8,
    parameter int unsigned FILL_DIV  = 2,
    parameter int unsigned GRAIN_VOL = 10,
    parameter int unsigned LEVEL_MAX = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       heat,
    input  logic       agitate,
    input  logic       chute,
    input  logic [2:0] pump,
    output logic [7:0] temp,
    output logic [7:0] level,
    output logic       overflow,
    output logic       dry_fire
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] HEAT_LIM_AG = CW'(HEAT_DIV - 1);
    localparam logic [CW-1:0] HEAT_LIM_NA = CW'(2 * HEAT_DIV - 1);
    localparam logic [CW-1:0] COOL_LIM    = CW'(COOL_DIV - 1);
    localparam logic [CW-1:0] FILL_LIM    = CW'(FILL_DIV - 1);
    localparam logic signed [9:0] LVL_MAX_S = 10'(LEVEL_MAX);
    localparam logic signed [9:0] GRAIN_S   = 10'(GRAIN_VOL);

    logic [7:0]    temp_q, temp_d;
    logic [7:0]    level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          dry_fire_q, dry_fire_d;
    logic [CW-1:0] heat_cnt_q, heat_cnt_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;
    logic [CW-1:0] pump_cnt_q, pump_cnt_d;
    logic          chute_q, chute_d;
    logic [1:0]    pump_code_q, pump_code_d;

    logic          heat_tick, cool_en, cool_tick, pump_valid, pump_tick;
    logic [CW-1:0] heat_lim, pump_cnt_eff;
    logic [8:0]    temp_sum;
    logic signed [9:0] step_s, fill_s, drain_s, grain_s, lvl_sum;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            temp_q      <= AMBIENT;
            level_q     <= 8'd0;
            overflow_q  <= 1'b0;
            dry_fire_q  <= 1'b0;
            heat_cnt_q  <= '0;
            cool_cnt_q  <= '0;
            pump_cnt_q  <= '0;
            chute_q     <= 1'b0;
            pump_code_q <= 2'b00;
        end else begin
            temp_q      <= temp_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            dry_fire_q  <= dry_fire_d;
            heat_cnt_q  <= heat_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            pump_cnt_q  <= pump_cnt_d;
            chute_q     <= chute_d;
            pump_code_q <= pump_code_d;
        end
    end

    // Prescalers, temperature and level update.
    always_comb begin
        temp_d      = temp_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        dry_fire_d  = dry_fire_q;
        chute_d     = chute;
        pump_code_d = pump[1:0];
        temp_sum    = '0;

        heat_lim   = agitate ? HEAT_LIM_AG : HEAT_LIM_NA;
        heat_tick  = heat && (heat_cnt_q >= heat_lim);
        heat_cnt_d = (!heat || heat_tick) ? '0 : heat_cnt_q + CW'(1);

        cool_en    = !heat && (temp_q > AMBIENT);
        cool_tick  = cool_en && (cool_cnt_q >= COOL_LIM);
        cool_cnt_d = (!cool_en || cool_tick) ? '0 : cool_cnt_q + CW'(1);

        // A direction change restarts the count; a speed change does not.
        pump_valid   = pump[0] ^ pump[1];
        pump_cnt_eff = (pump_code_q == pump[1:0]) ? pump_cnt_q : '0;
        pump_tick    = pump_valid && (pump_cnt_eff >= FILL_LIM);
        pump_cnt_d   = (!pump_valid || pump_tick) ? '0 : pump_cnt_eff + CW'(1);

        if (heat_tick) begin
            temp_sum = {1'b0, temp_q} + ((level_q == 8'd0) ? 9'd2 : 9'd1);
            temp_d   = temp_sum[8] ? 8'd255 : temp_sum[7:0];
            if (level_q == 8'd0) begin
                dry_fire_d = 1'b1;
            end
        end else if (cool_tick) begin
            temp_d = temp_q - 8'd1;
        end

        step_s  = pump[2] ? 10'sd2 : 10'sd1;
        fill_s  = (pump_tick && pump[0]) ? step_s : 10'sd0;
        drain_s = (pump_tick && pump[1]) ? step_s : 10'sd0;
        grain_s = (chute && !chute_q) ? GRAIN_S : 10'sd0;
        lvl_sum = $signed({2'b00, level_q}) + fill_s + grain_s - drain_s;

        if (lvl_sum < 10'sd0) begin
            level_d = 8'd0;
        end else if (lvl_sum > LVL_MAX_S) begin
            level_d    = 8'(LEVEL_MAX);
            overflow_d = 1'b1;
        end else begin
            level_d = lvl_sum[7:0];
        end
    end

    assign temp     = temp_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign dry_fire = dry_fire_q;

endmodule
